// File: rtl/noc_chain_pkg.sv
// Shared types and constants for the 1D NoC chain benchmark blocks.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents: checker state encoding, back-pressure LFSR taps, counter width,
// and the LFSR next-value helper used by the stall generator.
package noc_chain_pkg;

    localparam int unsigned CNT_W     = 16;
    // Taps at bits 7,5,4,3.
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Fibonacci step: shift left, feedback is the XOR of the tapped bits.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/noc_stall_lfsr.sv
// 8-bit Fibonacci LFSR producing a pseudo-random ready mask for sink stalls.
// Latency: mask is combinational from the LFSR register; LFSR steps once per enabled cycle.
// Backpressure: mask low (lfsr[1:0]==0) about one cycle in four.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (loads RESET_SEED)
//   seed        - value loaded on restart
//   enable      - advance the LFSR this cycle
//   restart     - reload seed this cycle (wins over enable)
//   ready_mask  - 1 when the sink may accept this cycle
module noc_stall_lfsr
    import noc_chain_pkg::*;
#(
    parameter logic [7:0] RESET_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seed,
    input  logic       enable,
    input  logic       restart,
    output logic       ready_mask
);

    logic [7:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= RESET_SEED;
        end else if (restart) begin
            lfsr_q <= seed;
        end else if (enable) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign ready_mask = (lfsr_q[1:0] != 2'b00);

endmodule

// File: rtl/noc_stream_checker.sv
// Self-checking AXI-Stream sink: compares accepted beats against an arithmetic sequence.
// Latency: zero-latency compare; counters/captures/state update on the accepting edge.
// Backpressure: tready low outside RUN; in RUN, optional LFSR stalls, never dependent on tvalid.
//
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   start                          - pulse; starts a run from IDLE or DONE
//   axis_in_tvalid/tdata/tready    - stream input from the last router
//   busy, done, pass               - run status; pass valid while done
//   beat_count, err_count          - accepted / mismatching beats this run
//   first_err_idx/data/exp         - capture of the first mismatching beat
module noc_stream_checker
    import noc_chain_pkg::*;
#(
    parameter int unsigned         DW          = 32,
    parameter logic [DW-1:0]       START_VALUE = {{(DW-1){1'b0}}, 1'b1},
    parameter logic [DW-1:0]       STEP        = {{(DW-1){1'b0}}, 1'b1},
    parameter logic [CNT_W-1:0]    NUM_BEATS   = 16'd256,
    parameter bit                  STALL_EN    = 1'b1,
    parameter logic [7:0]          LFSR_SEED   = 8'hA5,
    parameter bit                  STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             axis_in_tvalid,
    input  logic [DW-1:0]    axis_in_tdata,
    output logic             axis_in_tready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] beat_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [DW-1:0]    first_err_data,
    output logic [DW-1:0]    first_err_exp
);

    state_t            state_q;
    state_t            state_d;
    logic [DW-1:0]     exp_q;
    logic              ready_mask;
    logic              accept;
    logic              mismatch;
    logic              last_beat;
    logic              finish;
    logic              start_run;
    logic [CNT_W-1:0]  err_next;

    // A start pulse is only honoured outside RUN.
    assign start_run = start && (state_q != RUN);
    assign accept    = axis_in_tvalid && axis_in_tready;
    assign mismatch  = accept && (axis_in_tdata != exp_q);
    // NUM_BEATS == 0 means free-running: the last-beat condition never fires.
    assign last_beat = (NUM_BEATS != '0) && (beat_count == NUM_BEATS - 1'b1);
    assign finish    = accept && (last_beat || (STOP_ON_ERR && mismatch));
    // Saturating error count as it will be after this edge.
    assign err_next  = (mismatch && (err_count != '1)) ? err_count + 1'b1 : err_count;

    noc_stall_lfsr #(
        .RESET_SEED (LFSR_SEED)
    ) u_stall_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed       (LFSR_SEED),
        .enable     (state_q == RUN),
        .restart    (start_run),
        .ready_mask (ready_mask)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start)  state_d = RUN;
            RUN:        if (finish) state_d = DONE;
            default:                state_d = IDLE;
        endcase
    end

    // Outputs decoded from state (and LFSR for ready).
    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        axis_in_tready = 1'b0;
        unique case (state_q)
            RUN: begin
                busy           = 1'b1;
                axis_in_tready = STALL_EN ? ready_mask : 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Checking datapath: counters, expected value, first-error capture, verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q          <= START_VALUE;
            beat_count     <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            first_err_exp  <= '0;
            pass           <= 1'b0;
        end else if (start_run) begin
            exp_q          <= START_VALUE;
            beat_count     <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            first_err_exp  <= '0;
            pass           <= 1'b0;
        end else if (accept) begin
            beat_count <= beat_count + 1'b1;
            exp_q      <= exp_q + STEP;
            err_count  <= err_next;
            // err_count is still zero only if no earlier beat of this run failed.
            if (mismatch && (err_count == '0)) begin
                first_err_idx  <= beat_count;
                first_err_data <= axis_in_tdata;
                first_err_exp  <= exp_q;
            end
            // Verdict is frozen on the edge that enters DONE, including this beat.
            if (finish) begin
                pass <= (err_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_noc_stream_checker.sv
// Bench for noc_stream_checker: four instances with different parameter sets
// share one stream source and reset; each test starts exactly one of them.
module tb_noc_stream_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  start;
    logic        tvalid;
    logic [31:0] tdata;

    logic        tready [4];
    logic        busy   [4];
    logic        done   [4];
    logic        pass   [4];
    logic [15:0] bcnt   [4];
    logic [15:0] ecnt   [4];
    logic [15:0] fidx   [4];
    logic [31:0] fdat   [4];
    logic [31:0] fexp   [4];

    typedef struct {
        logic [15:0] bc;
        logic [15:0] ec;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // 0: basic 4-beat, no stalls
    noc_stream_checker #(.NUM_BEATS(16'd4), .STALL_EN(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .axis_in_tvalid(tvalid), .axis_in_tdata(tdata), .axis_in_tready(tready[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .beat_count(bcnt[0]), .err_count(ecnt[0]), .first_err_idx(fidx[0]),
        .first_err_data(fdat[0]), .first_err_exp(fexp[0]));

    // 1: default parameters, LFSR stalls, 256 beats
    noc_stream_checker u_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .axis_in_tvalid(tvalid), .axis_in_tdata(tdata), .axis_in_tready(tready[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .beat_count(bcnt[1]), .err_count(ecnt[1]), .first_err_idx(fidx[1]),
        .first_err_data(fdat[1]), .first_err_exp(fexp[1]));

    // 2: wrap-around start value, stop on first error
    noc_stream_checker #(.START_VALUE(32'hFFFF_FFFF), .NUM_BEATS(16'd4),
                         .STALL_EN(1'b0), .STOP_ON_ERR(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start[2]),
        .axis_in_tvalid(tvalid), .axis_in_tdata(tdata), .axis_in_tready(tready[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .beat_count(bcnt[2]), .err_count(ecnt[2]), .first_err_idx(fidx[2]),
        .first_err_data(fdat[2]), .first_err_exp(fexp[2]));

    // 3: free-running, for the mid-run reset test
    noc_stream_checker #(.NUM_BEATS(16'd0), .STALL_EN(1'b0)) u_d (
        .clk(clk), .rst_n(rst_n), .start(start[3]),
        .axis_in_tvalid(tvalid), .axis_in_tdata(tdata), .axis_in_tready(tready[3]),
        .busy(busy[3]), .done(done[3]), .pass(pass[3]),
        .beat_count(bcnt[3]), .err_count(ecnt[3]), .first_err_idx(fidx[3]),
        .first_err_data(fdat[3]), .first_err_exp(fexp[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start instance 'inst', stream 'data' with tvalid held high, and check
    // tready each cycle plus beat/error counts after every accept.
    task automatic run_stream(input int inst, input logic [31:0] data[$],
                              input bit stall, input logic [31:0] start_val);
        logic [7:0]  ml;
        logic [15:0] mbc;
        logic [15:0] mec;
        logic [31:0] mexp;
        exp_t        e;
        int          k;
        int          cyc;
        bit          rdy;
        ml = 8'hA5; mbc = 16'd0; mec = 16'd0; mexp = start_val; k = 0; cyc = 0;
        @(posedge clk); #1 start[inst] = 1'b1;
        @(posedge clk); #1 start[inst] = 1'b0;
        while (k < data.size() && done[inst] !== 1'b1 && cyc < 2000) begin
            tvalid = 1'b1;
            tdata  = data[k];
            rdy    = stall ? (ml[1:0] != 2'b00) : 1'b1;
            chk("tready", {31'd0, tready[inst]}, {31'd0, rdy});
            if (rdy) begin
                if (data[k] !== mexp && mec != 16'hFFFF) mec = mec + 16'd1;
                mbc  = mbc + 16'd1;
                mexp = mexp + 32'd1;
                sb.push_back('{bc: mbc, ec: mec});
                k++;
            end
            ml = {ml[6:0], ml[7] ^ ml[5] ^ ml[4] ^ ml[3]};
            @(posedge clk); #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("beat_count", {16'd0, bcnt[inst]}, {16'd0, e.bc});
                chk("err_count",  {16'd0, ecnt[inst]}, {16'd0, e.ec});
            end
            cyc++;
        end
        tvalid = 1'b0;
        chk("cycle_budget", {31'd0, (cyc < 2000)}, 32'd1);
    endtask

    initial begin
        logic [31:0] q[$];
        rst_n = 1'b0; start = 4'd0; tvalid = 1'b0; tdata = 32'd0;
        #1;
        chk("rst_busy",  {31'd0, busy[0]}, 32'd0);
        chk("rst_tready", {31'd0, tready[1]}, 32'd0);
        chk("rst_bcnt",  {16'd0, bcnt[0]}, 32'd0);
        chk("rst_done",  {31'd0, done[2]}, 32'd0);
        #20 rst_n = 1'b1;

        // Clean 4-beat run.
        q = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_stream(0, q, 1'b0, 32'd1);
        chk("t1_done",  {31'd0, done[0]}, 32'd1);
        chk("t1_pass",  {31'd0, pass[0]}, 32'd1);
        chk("t1_bcnt",  {16'd0, bcnt[0]}, 32'd4);
        chk("t1_ecnt",  {16'd0, ecnt[0]}, 32'd0);
        chk("t1_tready", {31'd0, tready[0]}, 32'd0);

        // One bad beat, restarted from DONE.
        q = '{32'd1, 32'd2, 32'd7, 32'd4};
        run_stream(0, q, 1'b0, 32'd1);
        chk("t2_done", {31'd0, done[0]}, 32'd1);
        chk("t2_pass", {31'd0, pass[0]}, 32'd0);
        chk("t2_ecnt", {16'd0, ecnt[0]}, 32'd1);
        chk("t2_fidx", {16'd0, fidx[0]}, 32'd2);
        chk("t2_fdat", fdat[0], 32'd7);
        chk("t2_fexp", fexp[0], 32'd3);

        // LFSR stalls, 256 correct beats.
        q = {};
        for (int i = 1; i <= 256; i++) q.push_back(32'(i));
        run_stream(1, q, 1'b1, 32'd1);
        chk("t3_done", {31'd0, done[1]}, 32'd1);
        chk("t3_pass", {31'd0, pass[1]}, 32'd1);
        chk("t3_bcnt", {16'd0, bcnt[1]}, 32'd256);

        // Wrap-around of the expected value.
        q = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2};
        run_stream(2, q, 1'b0, 32'hFFFF_FFFF);
        chk("t4_pass", {31'd0, pass[2]}, 32'd1);
        chk("t4_ecnt", {16'd0, ecnt[2]}, 32'd0);

        // Stop on error: second beat wrong.
        q = '{32'hFFFF_FFFF, 32'd5, 32'd1, 32'd2};
        run_stream(2, q, 1'b0, 32'hFFFF_FFFF);
        chk("t5_done", {31'd0, done[2]}, 32'd1);
        chk("t5_bcnt", {16'd0, bcnt[2]}, 32'd2);
        chk("t5_pass", {31'd0, pass[2]}, 32'd0);
        chk("t5_fidx", {16'd0, fidx[2]}, 32'd1);
        chk("t5_fdat", fdat[2], 32'd5);
        chk("t5_fexp", fexp[2], 32'd0);
        @(posedge clk); #1;
        chk("t5_tready_after", {31'd0, tready[2]}, 32'd0);
        chk("t5_bcnt_hold", {16'd0, bcnt[2]}, 32'd2);

        // Mid-run asynchronous reset.
        q = {};
        for (int i = 1; i <= 10; i++) q.push_back(32'(i));
        run_stream(3, q, 1'b0, 32'd1);
        chk("t6_busy_pre", {31'd0, busy[3]}, 32'd1);
        chk("t6_bcnt_pre", {16'd0, bcnt[3]}, 32'd10);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy",   {31'd0, busy[3]}, 32'd0);
        chk("t6_tready", {31'd0, tready[3]}, 32'd0);
        chk("t6_bcnt",   {16'd0, bcnt[3]}, 32'd0);
        chk("t6_a_done", {31'd0, done[0]}, 32'd0);
        chk("t6_a_fidx", {16'd0, fidx[0]}, 32'd0);
        chk("t6_a_fdat", fdat[0], 32'd0);
        #10 rst_n = 1'b1;
        q = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_stream(0, q, 1'b0, 32'd1);
        chk("t6_post_pass", {31'd0, pass[0]}, 32'd1);
        chk("t6_post_bcnt", {16'd0, bcnt[0]}, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
